// File: rtl/mem_access_if.sv
// Data-side SRAM-like bus between the memory-stage load/store unit and the data memory.
// A request is accepted on any cycle with data_req & data_addr_ok. Each accepted request gets exactly one data_data_ok, no earlier than the next cycle.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage load/store unit: issues one data access per instruction, formats store lanes,
// extends load data for writeback and stalls the stage while an access is outstanding.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_memreq,
  input  logic              m_memwrite,
  input  logic [1:0]        m_size,
  input  logic              m_sign,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_flush,
  input  logic              m_hold,
  mem_access_if.master      bus,
  output logic [DATA_W-1:0] rdata_out,
  output logic              m_stall,
  output logic [1:0]        dbg_state_o
);

  // Debug encoding: 0 idle, 1 waiting for data_ok, 2 result parked under hold, 3 draining a flushed access.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] saved_rdata_q;

  logic              mem_active;
  logic              req;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] src;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign mem_active = m_valid & m_memreq & ~m_flush;
  assign req        = ~rst & (state_q == S_IDLE) & mem_active;

  always_comb begin
    wdata = m_wdata;
    wstrb = 4'b1111;
    case (m_size)
      2'd0: begin
        wdata = {4{m_wdata[7:0]}};
        wstrb = 4'b0001 << m_addr[1:0];
      end
      2'd1: begin
        wdata = {2{m_wdata[15:0]}};
        wstrb = m_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = m_wdata;
        wstrb = 4'b1111;
      end
    endcase
  end

  assign bus.data_req   = req;
  assign bus.data_wr    = m_memwrite & req;
  assign bus.data_size  = m_size;
  assign bus.data_addr  = m_addr;
  assign bus.data_wdata = wdata;
  assign bus.data_wstrb = req ? wstrb : 4'b0000;

  // The data_ok cycle releases the stall so the result can move on in that same cycle.
  assign m_stall = ~rst & mem_active & (state_q != S_DONE) &
                   ~((state_q == S_WAIT) & bus.data_data_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      saved_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req & bus.data_addr_ok) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.data_data_ok) begin
            if (~m_flush & m_hold) begin
              state_q       <= S_DONE;
              saved_rdata_q <= bus.data_rdata;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (m_flush) begin
            state_q <= S_DISCARD;
          end
        end
        S_DONE: begin
          if (~m_hold | m_flush) state_q <= S_IDLE;
        end
        S_DISCARD: begin
          if (bus.data_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  // Outside WAIT the parked word is used, so a discarded access never reaches rdata_out.
  assign src      = (state_q == S_WAIT) ? bus.data_rdata : saved_rdata_q;
  assign byte_sel = src[{m_addr[1:0], 3'b000} +: 8];
  assign half_sel = m_addr[1] ? src[31:16] : src[15:0];

  always_comb begin
    rdata_out = src;
    case (m_size)
      2'd0:    rdata_out = {{24{m_sign & byte_sel[7]}}, byte_sel};
      2'd1:    rdata_out = {{16{m_sign & half_sel[15]}}, half_sel};
      default: rdata_out = src;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal expectations, then
// randomized pipeline and bus traffic checked every cycle against a transaction-level model.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        m_valid, m_memreq, m_memwrite, m_sign, m_flush, m_hold;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] rdata_out;
  logic        m_stall;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_valid    (m_valid),
    .m_memreq   (m_memreq),
    .m_memwrite (m_memwrite),
    .m_size     (m_size),
    .m_sign     (m_sign),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_flush    (m_flush),
    .m_hold     (m_hold),
    .bus        (bus.master),
    .rdata_out  (rdata_out),
    .m_stall    (m_stall),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction view) ----------------
  logic        outst;     // an accepted access has not seen its data_ok yet
  logic        dropped;   // that access was flushed; its result is thrown away
  logic        held;      // a load result is parked while the stage is frozen
  logic [31:0] saved;     // last result parked under hold

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
    int          nbits;
    int          shamt;
    logic [31:0] mask, v;
    nbits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    shamt = (sz == 2'd0) ? 8 * off : (sz == 2'd1) ? 16 * off[1] : 0;
    mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
    v     = (w >> shamt) & mask;
    if (sg && nbits < 32 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  logic        active, exp_req, exp_stall;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_wdata, exp_rdata;
  logic [1:0]  exp_state;

  always_comb begin
    active    = m_valid & m_memreq & ~m_flush;
    exp_req   = ~rst & ~outst & ~held & active;
    exp_stall = ~rst & active & ~held & ~(outst & ~dropped & bus.data_data_ok);
    exp_rdata = load_ext((outst & ~dropped) ? bus.data_rdata : saved, m_size, m_sign, m_addr[1:0]);
    exp_state = held ? 2'd2 : outst ? (dropped ? 2'd3 : 2'd1) : 2'd0;
    exp_wstrb = 4'b0000;
    if (exp_req) begin
      if (m_size == 2'd0)      exp_wstrb = 4'(1 << m_addr[1:0]);
      else if (m_size == 2'd1) exp_wstrb = m_addr[1] ? 4'b1100 : 4'b0011;
      else                     exp_wstrb = 4'b1111;
    end
    if (m_size == 2'd0)      exp_wdata = {24'h0, m_wdata[7:0]} * 32'h0101_0101;
    else if (m_size == 2'd1) exp_wdata = {16'h0, m_wdata[15:0]} * 32'h0001_0001;
    else                     exp_wdata = m_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      outst   <= 1'b0;
      dropped <= 1'b0;
      held    <= 1'b0;
      saved   <= 32'h0;
    end else begin
      if (exp_req && bus.data_addr_ok) begin
        outst   <= 1'b1;
        dropped <= 1'b0;
      end else if (outst && bus.data_data_ok) begin
        outst <= 1'b0;
        if (!dropped && !m_flush && m_hold) begin
          held  <= 1'b1;
          saved <= bus.data_rdata;
        end
      end else if (outst && m_flush) begin
        dropped <= 1'b1;
      end
      if (held && (!m_hold || m_flush)) held <= 1'b0;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    check("req",   {31'h0, bus.data_req},  {31'h0, exp_req});
    check("wr",    {31'h0, bus.data_wr},   {31'h0, exp_req & m_memwrite});
    check("wstrb", {28'h0, bus.data_wstrb}, {28'h0, exp_wstrb});
    check("stall", {31'h0, m_stall},       {31'h0, exp_stall});
    check("rdata", rdata_out, exp_rdata);
    check("state", {30'h0, dbg_state},     {30'h0, exp_state});
    if (exp_req) begin
      check("addr",  bus.data_addr, m_addr);
      check("size",  {30'h0, bus.data_size}, {30'h0, m_size});
      check("wdata", bus.data_wdata, exp_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drv(input logic v, mr, wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, wd, input logic fl, hd, aok, dok,
                     input logic [31:0] rd);
    @(posedge clk);
    #1;
    m_valid = v; m_memreq = mr; m_memwrite = wr; m_size = sz; m_sign = sg;
    m_addr = a; m_wdata = wd; m_flush = fl; m_hold = hd;
    bus.data_addr_ok = aok; bus.data_data_ok = dok; bus.data_rdata = rd;
  endtask

  task automatic bubble();
    drv(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic load2(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] rd, input logic [31:0] exp);
    drv(1, 1, 0, sz, sg, a, 32'h0, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("ld_issue_req", {31'h0, bus.data_req}, 32'h1);
    drv(1, 1, 0, sz, sg, a, 32'h0, 0, 0, 0, 1, rd);
    @(negedge clk);
    check("ld_result", rdata_out, exp);
    check("ld_stall_release", {31'h0, m_stall}, 32'h0);
    bubble();
  endtask

  // random-phase bus slave and pipeline bookkeeping
  logic       s_busy, acc_q, dok_q, adv;
  int         s_lat;

  initial begin
    rst = 1'b1;
    m_valid = 1; m_memreq = 1; m_memwrite = 0; m_size = 2'd2; m_sign = 0;
    m_addr = 32'h1000_0000; m_wdata = 0; m_flush = 0; m_hold = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 32'h0;
    @(negedge clk);
    check("rst_req",   {31'h0, bus.data_req}, 32'h0);
    check("rst_stall", {31'h0, m_stall}, 32'h0);
    check("rst_rdata", rdata_out, 32'h0);
    check("rst_wstrb", {28'h0, bus.data_wstrb}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bubble();

    // LW: addr_ok in cycle 0, data_ok in cycle 2
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0004, 32'h0, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("lw_c0_req", {31'h0, bus.data_req}, 32'h1);
    check("lw_c0_stall", {31'h0, m_stall}, 32'h1);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0004, 32'h0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("lw_c1_req", {31'h0, bus.data_req}, 32'h0);
    check("lw_c1_stall", {31'h0, m_stall}, 32'h1);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0004, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lw_c2_stall", {31'h0, m_stall}, 32'h0);
    check("lw_c2_rdata", rdata_out, 32'hDEAD_BEEF);
    check("lw_c2_req", {31'h0, bus.data_req}, 32'h0);
    bubble();

    load2(2'd0, 1, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    load2(2'd1, 0, 32'h1000_0002, 32'h80FF_1234, 32'h0000_80FF);

    // store lane formatting
    drv(1, 1, 1, 2'd0, 0, 32'h1000_0001, 32'h0000_00AB, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("sb_wdata", bus.data_wdata, 32'hABAB_ABAB);
    check("sb_wstrb", {28'h0, bus.data_wstrb}, 32'h2);
    check("sb_wr", {31'h0, bus.data_wr}, 32'h1);
    drv(1, 1, 1, 2'd1, 0, 32'h1000_0002, 32'h0000_CAFE, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("sh_wstrb", {28'h0, bus.data_wstrb}, 32'hC);
    check("sh_wdata", bus.data_wdata, 32'hCAFE_CAFE);
    bubble();

    // LW with hold during data_ok
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0010, 32'h0, 0, 0, 1, 0, 32'h0);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0010, 32'h0, 0, 1, 0, 1, 32'h1234_5678);
    @(negedge clk);
    check("hold_dok_rdata", rdata_out, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 2'd2, 0, 32'h1000_0010, 32'h0, 0, 1, 1, 0, 32'hAAAA_5555);
      @(negedge clk);
      check("done_state", {30'h0, dbg_state}, 32'h2);
      check("done_rdata", rdata_out, 32'h1234_5678);
      check("done_req", {31'h0, bus.data_req}, 32'h0);
      check("done_stall", {31'h0, m_stall}, 32'h0);
    end
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0010, 32'h0, 0, 0, 1, 0, 32'hAAAA_5555);
    @(negedge clk);
    check("done_release_req", {31'h0, bus.data_req}, 32'h0);
    bubble();
    @(negedge clk);
    check("after_done_idle", {30'h0, dbg_state}, 32'h0);

    // flush one cycle after addr_ok, data_ok two cycles later
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0008, 32'h0, 0, 0, 1, 0, 32'h0);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0008, 32'h0, 1, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("flush_stall", {31'h0, m_stall}, 32'h0);
    check("flush_req", {31'h0, bus.data_req}, 32'h0);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_000C, 32'h0, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("discard_state", {30'h0, dbg_state}, 32'h3);
    check("discard_req", {31'h0, bus.data_req}, 32'h0);
    check("discard_stall", {31'h0, m_stall}, 32'h1);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_000C, 32'h0, 0, 0, 1, 1, 32'hBAD0_BAD0);
    @(negedge clk);
    check("discard_dok_req", {31'h0, bus.data_req}, 32'h0);
    check("discard_dok_rdata", rdata_out, 32'h1234_5678);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_000C, 32'h0, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("after_discard_req", {31'h0, bus.data_req}, 32'h1);
    drv(1, 1, 0, 2'd2, 0, 32'h1000_000C, 32'h0, 0, 0, 0, 1, 32'h0000_1111);
    @(negedge clk);
    check("after_discard_rdata", rdata_out, 32'h0000_1111);
    bubble();

    // reset while waiting
    drv(1, 1, 0, 2'd2, 0, 32'h1000_0020, 32'h0, 0, 0, 1, 0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_addr_ok = 0;
    @(negedge clk);
    check("rst_wait_state", {30'h0, dbg_state}, 32'h0);
    check("rst_wait_req", {31'h0, bus.data_req}, 32'h0);
    check("rst_wait_stall", {31'h0, m_stall}, 32'h0);
    check("rst_wait_rdata", rdata_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bubble();

    // randomized traffic
    s_busy = 0; s_lat = 0; acc_q = 0; dok_q = 0; adv = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (rst) begin
        s_busy = 0; acc_q = 0; dok_q = 0; adv = 1;
      end
      if (acc_q) begin
        s_busy = 1; s_lat = $urandom_range(0, 3);
      end else if (s_busy && dok_q) begin
        s_busy = 0;
      end else if (s_busy && s_lat != 0) begin
        s_lat--;
      end
      rst = (cyc % 900 == 450);
      if (adv) begin
        m_valid    = ($urandom_range(0, 4) != 0);
        m_memreq   = ($urandom_range(0, 3) != 0);
        m_memwrite = $urandom_range(0, 1) == 1;
        m_size     = 2'($urandom_range(0, 3));
        m_sign     = $urandom_range(0, 1) == 1;
        m_wdata    = $urandom;
        m_addr     = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2);
        if (m_size == 2'd0)      m_addr[1:0] = 2'($urandom_range(0, 3));
        else if (m_size == 2'd1) m_addr[1]   = $urandom_range(0, 1) == 1;
      end
      m_hold  = ($urandom_range(0, 3) == 0);
      m_flush = m_valid && ($urandom_range(0, 11) == 0);
      bus.data_addr_ok = !s_busy && ($urandom_range(0, 2) != 0);
      bus.data_data_ok = s_busy && (s_lat == 0);
      bus.data_rdata   = $urandom;
      @(negedge clk);
      acc_q = bus.data_req & bus.data_addr_ok;
      dok_q = bus.data_data_ok;
      adv   = m_flush | (!m_hold && !(m_valid && exp_stall));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage load/store unit of the 5-stage MIPS pipeline; sits directly upstream of the writeback stage.
- Issues data-side SRAM-like requests and formats store data and byte strobes.
- Extends load data into the rdata_out value that the M/W register carries to writeback.
- Generates the memory-stage stall while a transaction is outstanding, and absorbs flushes and downstream holds without losing or duplicating accesses.

Parameters:
- ADDR_W, 32, data address width.
- DATA_W, 32, data bus width; only 32 is supported, and lane logic assumes 4 bytes.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- m_valid  in  1  memory stage holds a valid instruction.
- m_memreq  in  1  instruction accesses memory; already qualified against misalignment and address exceptions.
- m_memwrite  in  1  1 = store, 0 = load.
- m_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- m_sign  in  1  sign-extend loads.
- m_addr  in  ADDR_W  effective address (ex_out).
- m_wdata  in  DATA_W  store source register value.
- m_flush  in  1  exception or eret flush of the memory stage.
- m_hold  in  1  pipeline freeze from another stage; the instruction stays in the memory stage.
- data_req  out  1  request valid.
- data_wr  out  1  write request.
- data_size  out  2  equals m_size.
- data_addr  out  ADDR_W  equals m_addr.
- data_wdata  out  DATA_W  lane-replicated store data.
- data_wstrb  out  4  byte strobes.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid, or write complete.
- data_rdata  in  DATA_W  raw read word.
- rdata_out  out  DATA_W  extended load result to the M/W register.
- m_stall  out  1  memory stage cannot advance.

Behaviour:
- States: IDLE, WAIT, DONE, DISCARD. Reset (async, rst = 1) puts the block in IDLE and clears saved_rdata (32'b0). Reset mid-transaction abandons it; the bus side shares rst.
- Output reset values: data_req = 0, m_stall = 0, rdata_out = 0, data_wr = 0, data_wstrb = 0.
- Request signals are combinational, so zero-cycle issue is possible.
- data_req = (state == IDLE) & m_valid & m_memreq & ~m_flush.
- data_wr = m_memwrite & data_req; data_wstrb is forced to 0 when ~data_req.
- Store lanes:
  - byte: wdata = {4{m_wdata[7:0]}}, wstrb = 4'b0001 << m_addr[1:0].
  - half: wdata = {2{m_wdata[15:0]}}, wstrb = m_addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = m_wdata, wstrb = 4'b1111.
- IDLE:
  - data_req & data_addr_ok -> WAIT.
  - Otherwise stay; req stays asserted until addr_ok.
  - Flush drops req with no handshake, which is legal before addr_ok.
- WAIT:
  - data_data_ok & ~m_flush & ~m_hold -> IDLE.
  - data_data_ok & ~m_flush & m_hold -> DONE, capturing data_rdata into saved_rdata.
  - data_data_ok & m_flush -> IDLE, result dropped.
  - ~data_data_ok & m_flush -> DISCARD.
- data_data_ok never arrives in the same cycle as its own addr_ok; it is earliest the next cycle. data_data_ok seen in IDLE or DONE is a protocol error and is ignored.
- DONE:
  - ~m_hold or m_flush -> IDLE.
  - No re-issue for the held instruction.
- DISCARD:
  - data_data_ok -> IDLE; the data is ignored.
  - No req is issued; a new instruction waits.
- Load extraction: src = (state == WAIT) ? data_rdata : saved_rdata.
  - Byte: lane = m_addr[1:0].
  - Half: lane = m_addr[1].
  - Extension is sign or zero per m_sign.
  - rdata_out is combinational from src. It is valid in the data_ok cycle and throughout DONE.
- m_stall = m_valid & m_memreq & ~m_flush & ~(state == DONE) & ~(state == WAIT & data_data_ok).
  - This covers IDLE until issue, WAIT until data_ok, and DISCARD.
  - m_stall is never asserted when m_memreq = 0 or m_flush = 1.
- Back-to-back: from IDLE after data_ok, the next instruction issues the following cycle.
- Stores follow the same FSM; data_ok is the write-complete signal.

Test Plan:
- LW, addr 0x1000_0004: addr_ok in cycle 0, data_ok in cycle 2 with rdata 0xDEADBEEF -> m_stall = 1 in cycles 0–1 and 0 in cycle 2; rdata_out = 0xDEADBEEF in cycle 2; one req only.
- LB signed, addr ...03, rdata 0x80FF_1234 -> rdata_out = 0xFFFF_FF80. LHU, addr ...02, same rdata -> rdata_out = 0x0000_80FF.
- SB, addr ...01, m_wdata 0x0000_00AB -> data_wdata = 0xABABABAB, data_wstrb = 4'b0010, data_wr = 1. SH, addr ...02 -> data_wstrb = 4'b1100.
- LW with m_hold = 1 during data_ok (rdata 0x1234_5678), hold released 3 cycles later -> state DONE; rdata_out stays 0x1234_5678; data_req = 0 in DONE; m_stall = 0.
- m_flush one cycle after addr_ok, data_ok 2 cycles later, new LW presented -> DISCARD; new req is delayed until the cycle after the discarded data_ok; the flushed data never appears on rdata_out.
- rst pulsed while in WAIT -> immediately IDLE, data_req = 0, m_stall = 0, rdata_out = 0.
